rotr_seq: RTL and testbench

Sequential right-direction shifter for the 16-bit datapath: the multi-cycle, one-bit-per-cycle counterpart of the left-rotate stages used in the barrel shifter. It accepts an operand, a 4-bit count and an operation code. It performs rotate-right, logical shift-right or arithmetic shift-right, one bit position per clock, then reports completion with a one-cycle done pulse. It serves as the low-area right-shift path and as a golden sequential model for checking the combinational shifter.

---
 rtl/rotr_seq.sv | 116 +++++++++++
 tb/tb_rotr_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotr_seq.sv
// -----------------------------------------------------------------------------
// rotr_seq -- sequential right shifter, one bit position per clock.
//
// Performs rotate-right, logical shift-right or arithmetic shift-right of a
// 16-bit operand by 0..15 positions. The result register steps one bit per
// cycle, and a one-cycle done pulse marks completion.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   request, sampled only while ready (IDLE or DONE)
//   In     in  16   operand, captured on the accepting edge
//   Cnt    in   4   shift amount, captured on the accepting edge
//   Op     in   2   00 ror, 01 srl, 10 sra, 11 ror
//   busy   out  1   high while shifting
//   done   out  1   one-cycle completion pulse
//   Out    out 16   result register
// -----------------------------------------------------------------------------
module rotr_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] In,
    input  logic [3:0]  Cnt,
    input  logic [1:0]  Op,
    output logic        busy,
    output logic        done,
    output logic [15:0] Out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_r;
    logic [15:0] data_r;
    logic [3:0]  rem_r;
    logic [1:0]  op_r;
    logic        busy_r;
    logic        done_r;

    // One-bit right step; op code 11 deliberately falls into the rotate branch.
    function automatic logic [15:0] step_right(input logic [15:0] d,
                                               input logic [1:0]  op);
        logic [15:0] r;
        case (op)
            2'b01:   r = {1'b0,  d[15:1]};
            2'b10:   r = {d[15], d[15:1]};
            default: r = {d[0],  d[15:1]};
        endcase
        return r;
    endfunction

    // Control FSM, operand registers and registered status flags.
    // busy_r/done_r are written with the value matching the next state so
    // they track the state register without any decode from the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            data_r  <= 16'h0000;
            rem_r   <= 4'd0;
            op_r    <= 2'b00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        data_r <= In;
                        rem_r  <= Cnt;
                        op_r   <= Op;
                        if (Cnt != 4'd0) begin
                            state_r <= SHIFT;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end else begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                SHIFT: begin
                    data_r <= step_right(data_r, op_r);
                    rem_r  <= rem_r - 4'd1;
                    // rem_r==1 means this edge performs the final step.
                    if (rem_r == 4'd1) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= SHIFT;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign Out  = data_r;

endmodule

// File: tb/tb_rotr_seq.sv
// -----------------------------------------------------------------------------
// tb_rotr_seq -- self-checking bench for rotr_seq.
// A driver pushes expected result, busy length and done cycle into a
// scoreboard queue on each accepted start; a monitor pops and compares on
// every done pulse and checks that Out holds while idle.
// -----------------------------------------------------------------------------
module tb_rotr_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] din;
    logic [3:0]  cnt;
    logic [1:0]  op;
    logic        busy;
    logic        done;
    logic [15:0] dout;

    rotr_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .In    (din),
        .Cnt   (cnt),
        .Op    (op),
        .busy  (busy),
        .done  (done),
        .Out   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] out;
        int          busy_len;
        int          due;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [15:0] in;
        logic [3:0]  cnt;
        logic [1:0]  op;
        logic [15:0] exp;
    } vec_t;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model built from whole-word shift operators.
    function automatic logic [15:0] model(input logic [15:0] i, input logic [3:0] c, input logic [1:0] o);
        logic [15:0] r;
        logic [31:0] w;
        case (o)
            2'b01:   r = i >> c;
            2'b10:   r = $signed(i) >>> c;
            default: begin
                w = {i, i} >> c;
                r = w[15:0];
            end
        endcase
        return r;
    endfunction

    // Called at a negedge; waits until ready, drives one start cycle.
    task automatic issue(input logic [15:0] i, input logic [3:0] c, input logic [1:0] o,
                         input logic [15:0] e);
        int g;
        exp_t x;
        g = 0;
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: busy stuck high, expected low within 100 cycles");
        end
        start = 1'b1;
        din   = i;
        cnt   = c;
        op    = o;
        x.out = e;
        x.busy_len = int'(c);
        x.due = cyc + 1 + int'(c);
        sbq.push_back(x);
        @(negedge clk);
        start = 1'b0;
        din   = 16'($urandom);
        cnt   = 4'($urandom);
        op    = 2'($urandom);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sbq.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // Monitor: scoreboard compare on done, busy length, Out hold while idle.
    int          busy_cnt = 0;
    bit          have_res = 0;
    logic [15:0] last_res = 16'h0000;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
                have_res = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: done=1 with no pending op, expected 0 (t=%0t)", $time);
                    end else begin
                        e = sbq.pop_front();
                        check16("result", dout, e.out);
                        check_int("done_cycle", cyc, e.due);
                        check_int("busy_cycles", busy_cnt, e.busy_len);
                        busy_cnt = 0;
                        have_res = 1;
                        last_res = e.out;
                    end
                end else if (!busy && have_res) begin
                    check16("idle_hold", dout, last_res);
                end
            end
        end
    end

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{16'h8001, 4'd1,  2'b00, 16'hC000};
        vecs[1]  = '{16'h8000, 4'd15, 2'b01, 16'h0001};
        vecs[2]  = '{16'h8000, 4'd15, 2'b10, 16'hFFFF};
        vecs[3]  = '{16'h8421, 4'd4,  2'b10, 16'hF842};
        vecs[4]  = '{16'h8421, 4'd4,  2'b11, 16'h1842};
        vecs[5]  = '{16'h1234, 4'd0,  2'b00, 16'h1234};
        vecs[6]  = '{16'h1234, 4'd0,  2'b01, 16'h1234};
        vecs[7]  = '{16'h1234, 4'd0,  2'b10, 16'h1234};
        vecs[8]  = '{16'h1234, 4'd0,  2'b11, 16'h1234};
        vecs[9]  = '{16'hF0F0, 4'd4,  2'b01, 16'h0F0F};
        vecs[10] = '{16'h7FFF, 4'd15, 2'b10, 16'h0000};
        vecs[11] = '{16'h1234, 4'd15, 2'b00, 16'h2468};
        vecs[12] = '{16'h8000, 4'd1,  2'b10, 16'hC000};

        rst_n = 1'b0;
        start = 1'b0;
        din   = 16'hFFFF;
        cnt   = 4'd7;
        op    = 2'b01;
        @(negedge clk);
        @(negedge clk);
        check16("reset_out", dout, 16'h0000);
        check16("reset_busy", {15'd0, busy}, 16'h0000);
        check16("reset_done", {15'd0, done}, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, drained one by one (Cnt=0 cases never raise busy).
        for (int k = 0; k < 13; k++) begin
            issue(vecs[k].in, vecs[k].cnt, vecs[k].op, vecs[k].exp);
            drain();
        end

        // Same table back-to-back, exercising acceptance in the DONE cycle.
        for (int k = 0; k < 13; k++) begin
            issue(vecs[k].in, vecs[k].cnt, vecs[k].op, vecs[k].exp);
        end
        drain();

        // start during SHIFT is ignored; start in DONE is accepted.
        issue(16'h00FF, 4'd8, 2'b00, 16'hFF00);
        start = 1'b1;
        din   = 16'hFFFF;
        cnt   = 4'd3;
        op    = 2'b01;
        @(negedge clk);
        start = 1'b0;
        begin
            int g;
            g = 0;
            while (busy && g < 50) begin
                @(negedge clk);
                g++;
            end
        end
        check16("b2b_in_done", {15'd0, done}, 16'h0001);
        issue(16'h0001, 4'd1, 2'b00, 16'h8000);
        drain();

        // Reset in the third SHIFT cycle aborts without a done pulse.
        start = 1'b1;
        din   = 16'hABCD;
        cnt   = 4'd10;
        op    = 2'b00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check16("abort_busy_pre", {15'd0, busy}, 16'h0001);
        rst_n = 1'b0;
        #1;
        check16("abort_out", dout, 16'h0000);
        check16("abort_busy", {15'd0, busy}, 16'h0000);
        check16("abort_done", {15'd0, done}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        issue(16'h8421, 4'd4, 2'b10, 16'hF842);
        drain();

        // Random operations against the reference model.
        for (int k = 0; k < 25; k++) begin
            logic [15:0] ri;
            logic [3:0]  rc;
            logic [1:0]  ro;
            ri = 16'($urandom);
            rc = 4'($urandom_range(0, 15));
            ro = 2'($urandom_range(0, 3));
            issue(ri, rc, ro, model(ri, rc, ro));
            if (($urandom & 32'd1) == 32'd1) drain();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
